// File: rtl/io_port_pkg.sv
// Register offsets and CTRL bit positions shared by the MMIO I/O port.
package io_port_pkg;

    localparam logic [2:0] OFF_HEX  = 3'd0;
    localparam logic [2:0] OFF_LED  = 3'd1;
    localparam logic [2:0] OFF_CTRL = 3'd2;
    localparam logic [2:0] OFF_BTN  = 3'd3;
    localparam logic [2:0] OFF_SW   = 3'd4;
    localparam int         N_REGS   = 5;

    localparam int CTRL_BLANK    = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_MASK_LSB = 2;

endpackage

// File: rtl/hex_seg_dec.sv
// Nibble to active-low 7-segment pattern; bit7 is the decimal point, held off.
module hex_seg_dec (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/mmio_io_port.sv
// Memory-mapped register bank driving 7-seg digits and LEDs, with debounced
// buttons (sticky W1C press flags) and synchronised switches readable by the CPU.
module mmio_io_port #(
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'h6000,
    parameter int                DIGITS          = 4,
    parameter int                N_LED           = 10,
    parameter int                N_BTN           = 3,
    parameter int                N_SW            = 10,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                BLINK_DIV       = 12500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address_m,
    input  logic [DATA_W-1:0]   out_m,
    input  logic                write_m,
    output logic [DATA_W-1:0]   rdata,
    output logic                hit,
    input  logic [N_BTN-1:0]    btn_n,
    input  logic [N_SW-1:0]     sw,
    output logic [N_LED-1:0]    led,
    output logic [DIGITS*8-1:0] hex_seg
);
    import io_port_pkg::*;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BL_W = $clog2(BLINK_DIV);

    logic [ADDR_W-1:0]   offset;
    logic [2:0]          reg_sel;
    logic                wr_en;
    logic [DIGITS*4-1:0] hex_reg;
    logic [N_LED-1:0]    led_reg;
    logic [DIGITS+1:0]   ctrl_reg;
    logic [N_BTN-1:0]    btn_s1, btn_s2, stable, rise, flags, flag_clr;
    logic [N_SW-1:0]     sw_s1, sw_s2;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_phase;
    logic [DIGITS*8-1:0] dec_seg, seg_next;
    logic                unused_ok;

    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign offset    = address_m - BASE_ADDR;
    assign hit       = (offset < ADDR_W'(N_REGS));
    assign reg_sel   = offset[2:0];
    assign wr_en     = write_m && hit;
    assign led       = led_reg;
    assign unused_ok = ^out_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_reg  <= '0;
            led_reg  <= '0;
            ctrl_reg <= {{DIGITS{1'b1}}, 2'b00};
        end else if (wr_en) begin
            case (reg_sel)
                OFF_HEX:  hex_reg  <= out_m[DIGITS*4-1:0];
                OFF_LED:  led_reg  <= out_m[N_LED-1:0];
                OFF_CTRL: ctrl_reg <= out_m[DIGITS+1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= ~btn_n;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            stable_q;
        logic            accept;

        assign accept    = (btn_s2[i] != stable_q) && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        assign rise[i]   = accept && btn_s2[i];
        assign stable[i] = stable_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                stable_q <= 1'b0;
            end else if (btn_s2[i] == stable_q) begin
                cnt <= '0;
            end else if (accept) begin
                cnt      <= '0;
                stable_q <= btn_s2[i];
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    // A new press in the same cycle as a W1C clear leaves the flag set.
    assign flag_clr = (wr_en && reg_sel == OFF_BTN) ? out_m[2*N_BTN-1:N_BTN] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags <= '0;
        else          flags <= (flags & ~flag_clr) | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        logic blank_d;

        hex_seg_dec u_dec (
            .nibble(hex_reg[4*d +: 4]),
            .seg   (dec_seg[8*d +: 8])
        );

        assign blank_d = ctrl_reg[CTRL_BLANK] || !ctrl_reg[CTRL_MASK_LSB + d] ||
                         (ctrl_reg[CTRL_BLINK_EN] && blink_phase);
        assign seg_next[8*d +: 8] = blank_d ? 8'hFF : dec_seg[8*d +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hex_seg <= {DIGITS{8'hC0}};
        else          hex_seg <= seg_next;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                OFF_HEX:  rdata[DIGITS*4-1:0] = hex_reg;
                OFF_LED:  rdata[N_LED-1:0]    = led_reg;
                OFF_CTRL: rdata[DIGITS+1:0]   = ctrl_reg;
                OFF_BTN:  rdata[2*N_BTN-1:0]  = {flags, stable};
                OFF_SW:   rdata[N_SW-1:0]     = sw_s2;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_io_port.sv
// Directed bench for mmio_io_port: register table plus hex latency, blink,
// debounce/W1C, switch sync and asynchronous reset sequences.
module tb_mmio_io_port;

    localparam logic [15:0] BASE = 16'h6000;

    logic        clk;
    logic        reset_n;
    logic [15:0] address_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [15:0] rdata;
    logic        hit;
    logic [2:0]  btn_n;
    logic [9:0]  sw;
    logic [9:0]  led;
    logic [31:0] hex_seg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    mmio_io_port #(
        .DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'h6000), .DIGITS(4),
        .N_LED(10), .N_BTN(3), .N_SW(10), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address_m(address_m),
        .out_m    (out_m),
        .write_m  (write_m),
        .rdata    (rdata),
        .hit      (hit),
        .btn_n    (btn_n),
        .sw       (sw),
        .led      (led),
        .hex_seg  (hex_seg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges since reset release, used to predict blink phase
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input logic [15:0] exp);
        address_m = addr;
        write_m   = 1'b0;
        #1;
        check(name, {16'h0, rdata}, {16'h0, exp});
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        address_m = addr;
        out_m     = data;
        write_m   = 1'b1;
        tick();
        write_m   = 1'b0;
    endtask

    typedef struct {
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
        logic [15:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] exp_seg;
        int          ph;

        vecs[0] = '{BASE,          16'h1A2F, BASE,          16'h1A2F, 1'b1};
        vecs[1] = '{BASE + 16'd1,  16'hFFFF, BASE + 16'd1,  16'h03FF, 1'b1};
        vecs[2] = '{BASE + 16'd1,  16'h0205, BASE + 16'd1,  16'h0205, 1'b1};
        vecs[3] = '{BASE + 16'd5,  16'hFFFF, BASE + 16'd5,  16'h0000, 1'b0};
        vecs[4] = '{BASE - 16'd1,  16'hFFFF, BASE - 16'd1,  16'h0000, 1'b0};
        vecs[5] = '{BASE + 16'd4,  16'hFFFF, BASE + 16'd4,  16'h0000, 1'b1};
        vecs[6] = '{BASE + 16'd3,  16'hFFFF, BASE + 16'd3,  16'h0000, 1'b1};
        vecs[7] = '{BASE + 16'd5,  16'hFFFF, BASE + 16'd2,  16'h003C, 1'b1};

        reset_n   = 1'b0;
        address_m = BASE;
        out_m     = 16'h0;
        write_m   = 1'b0;
        btn_n     = 3'b111;
        sw        = 10'h0;
        repeat (3) tick();

        check("rst_led", {22'h0, led}, 32'h0);
        check("rst_hex_seg", hex_seg, 32'hC0C0C0C0);
        rd_check("rst_hex", BASE, 16'h0000);
        rd_check("rst_ctrl", BASE + 16'd2, 16'h003C);
        rd_check("rst_btn", BASE + 16'd3, 16'h0000);
        rd_check("rst_sw", BASE + 16'd4, 16'h0000);
        reset_n = 1'b1;
        tick();

        // write HEX: rdata old in write cycle, hex_seg two edges later
        address_m = BASE;
        out_m     = 16'h1A2F;
        write_m   = 1'b1;
        #1;
        check("hex_rd_old", {16'h0, rdata}, 32'h0);
        tick();
        check("hex_rd_new", {16'h0, rdata}, 32'h1A2F);
        check("hex_seg_edge_k", hex_seg, 32'hC0C0C0C0);
        write_m = 1'b0;
        tick();
        check("hex_seg_edge_k1", hex_seg, 32'hF988A48E);

        wr(BASE + 16'd1, 16'h0205);
        check("led_one_edge", {22'h0, led}, 32'h205);

        // register table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd_check($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
            check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
        end
        check("led_after_table", {22'h0, led}, 32'h205);
        check("hex_after_table", hex_seg, 32'hF988A48E);

        // CTRL blank + blink, then blink only
        wr(BASE + 16'd2, 16'h002B);
        tick();
        check("ctrl_blank_all", hex_seg, 32'hFFFFFFFF);
        wr(BASE + 16'd2, 16'h002A);
        for (int k = 0; k < 20; k++) begin
            tick();
            ph      = ((cyc - 1) / 8) % 2;
            exp_seg = {(ph != 0) ? 8'hFF : 8'hF9, 8'hFF, (ph != 0) ? 8'hFF : 8'hA4, 8'hFF};
            check($sformatf("blink_%0d", k), hex_seg, exp_seg);
        end
        wr(BASE + 16'd2, 16'h003C);

        // glitch of 3 cycles on btn 1
        btn_n = 3'b101;
        repeat (3) tick();
        btn_n = 3'b111;
        repeat (8) tick();
        rd_check("btn_glitch", BASE + 16'd3, 16'h0000);

        // held press; W1C in the flag-set cycle loses to the set
        tick();
        btn_n = 3'b101;
        repeat (5) tick();
        rd_check("btn_edge5", BASE + 16'd3, 16'h0000);
        out_m   = 16'h0010;
        write_m = 1'b1;
        tick();
        check("btn_edge6_set_wins", {16'h0, rdata}, 32'h0012);
        write_m = 1'b0;
        tick();
        check("btn_edge7", {16'h0, rdata}, 32'h0012);
        repeat (3) tick();
        btn_n = 3'b111;
        repeat (8) tick();
        rd_check("btn_released", BASE + 16'd3, 16'h0010);
        wr(BASE + 16'd3, 16'h0007);
        rd_check("btn_w1c_other", BASE + 16'd3, 16'h0010);
        wr(BASE + 16'd3, 16'h0010);
        rd_check("btn_w1c_clear", BASE + 16'd3, 16'h0000);

        // switches
        sw = 10'h3FF;
        tick();
        rd_check("sw_edge1", BASE + 16'd4, 16'h0000);
        tick();
        rd_check("sw_edge2", BASE + 16'd4, 16'h03FF);
        rd_check("sw_btn_unchanged", BASE + 16'd3, 16'h0000);
        wr(BASE + 16'd4, 16'h0000);
        rd_check("sw_write_ignored", BASE + 16'd4, 16'h03FF);

        // asynchronous reset mid-blink and mid-debounce
        wr(BASE + 16'd2, 16'h003E);
        wr(BASE + 16'd1, 16'h0155);
        btn_n = 3'b110;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("arst_led", {22'h0, led}, 32'h0);
        check("arst_hex_seg", hex_seg, 32'hC0C0C0C0);
        rd_check("arst_hex", BASE, 16'h0000);
        rd_check("arst_ctrl", BASE + 16'd2, 16'h003C);
        rd_check("arst_btn", BASE + 16'd3, 16'h0000);
        rd_check("arst_sw", BASE + 16'd4, 16'h0000);
        btn_n = 3'b111;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        rd_check("post_rst_btn", BASE + 16'd3, 16'h0000);
        rd_check("post_rst_sw", BASE + 16'd4, 16'h03FF);
        check("post_rst_hex_seg", hex_seg, 32'hC0C0C0C0);
        check("post_rst_led", {22'h0, led}, 32'h0);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
